// File: rtl/iiitb_ptv_pkg.sv
// Shared types and default constants for the ticket-printer dispense arbiter.
package iiitb_ptv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam int DEF_N_KIOSK       = 4;
  localparam int DEF_STOCK_W       = 8;
  localparam int DEF_STOCK_INIT    = 255;
  localparam int DEF_TMO_W         = 5;
  localparam int DEF_PRINT_TIMEOUT = 16;

endpackage

// File: rtl/iiitb_ptv_dispense_arb_if.sv
// Kiosk/printer handshake bundle for the dispense arbiter.
// The arbiter uses the slave modport; the kiosk/printer side uses master.
interface iiitb_ptv_dispense_arb_if
  import iiitb_ptv_pkg::*;
#(
  parameter int N_KIOSK = DEF_N_KIOSK,
  parameter int STOCK_W = DEF_STOCK_W
);

  logic [N_KIOSK-1:0] req;
  logic [N_KIOSK-1:0] grant;
  logic [N_KIOSK-1:0] ack;
  logic               prn_start;
  logic               prn_done;
  logic               refill;
  logic               clr_fault;
  logic [STOCK_W-1:0] stock;
  logic               empty;
  logic               fault;

  modport master (
    output req, prn_done, refill, clr_fault,
    input  grant, ack, prn_start, stock, empty, fault
  );

  modport slave (
    input  req, prn_done, refill, clr_fault,
    output grant, ack, prn_start, stock, empty, fault
  );

endinterface

// File: rtl/iiitb_ptv_rr_pick.sv
// Combinational round-robin picker: first requester after the last served index.
// With IIITB_PTV_PRIO_EN defined, kiosk 0 always wins and the rest rotate.
module iiitb_ptv_rr_pick
  import iiitb_ptv_pkg::*;
#(
  parameter int N_KIOSK = DEF_N_KIOSK,
  parameter int IDX_W   = $clog2(N_KIOSK)
) (
  input  logic [N_KIOSK-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [N_KIOSK-1:0] pick,
  output logic [IDX_W-1:0]   idx
);

  logic [N_KIOSK-1:0] rr_req_s;
  logic [IDX_W-1:0]   cand_s;
  logic               found_s;

  // search the rotated request vector, then apply the optional kiosk-0 override
  always_comb begin
    pick    = {N_KIOSK{1'b0}};
    idx     = {IDX_W{1'b0}};
    found_s = 1'b0;
    cand_s  = {IDX_W{1'b0}};
`ifdef IIITB_PTV_PRIO_EN
    rr_req_s = {req[N_KIOSK-1:1], 1'b0};
`else
    rr_req_s = req;
`endif
    for (int k = 1; k <= N_KIOSK; k++) begin
      cand_s = IDX_W'((int'(last) + k) % N_KIOSK);
      if (!found_s && rr_req_s[cand_s]) begin
        found_s = 1'b1;
        idx     = cand_s;
      end else begin
        found_s = found_s;
      end
    end
`ifdef IIITB_PTV_PRIO_EN
    if (req[0]) begin
      found_s = 1'b1;
      idx     = {IDX_W{1'b0}};
    end else begin
      found_s = found_s;
    end
`endif
    if (found_s) begin
      pick = {{(N_KIOSK-1){1'b0}}, 1'b1} << idx;
    end else begin
      pick = {N_KIOSK{1'b0}};
    end
  end

endmodule

// File: rtl/iiitb_ptv_dispense_arb.sv
// Shared ticket-printer arbiter: round-robin grant, printer start/done handshake,
// stock tracking and timeout fault. Optional macro IIITB_PTV_PRIO_EN gives kiosk 0 priority.
module iiitb_ptv_dispense_arb
  import iiitb_ptv_pkg::*;
#(
  parameter int N_KIOSK       = DEF_N_KIOSK,
  parameter int STOCK_W       = DEF_STOCK_W,
  parameter int STOCK_INIT    = DEF_STOCK_INIT,
  parameter int TMO_W         = DEF_TMO_W,
  parameter int PRINT_TIMEOUT = DEF_PRINT_TIMEOUT
) (
  input logic                    clk,
  input logic                    rst,
  iiitb_ptv_dispense_arb_if.slave bus
);

  localparam int                 IDX_W      = $clog2(N_KIOSK);
  localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0] STOCK_ONE  = STOCK_W'(1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(PRINT_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]   TMO_ONE    = TMO_W'(1);
  localparam logic [IDX_W-1:0]   LAST_INIT  = IDX_W'(N_KIOSK - 1);

  state_t             state_r,  state_nxt;
  logic [N_KIOSK-1:0] grant_r,  grant_nxt;
  logic [IDX_W-1:0]   gidx_r,   gidx_nxt;
  logic [N_KIOSK-1:0] ack_r,    ack_nxt;
  logic               start_r,  start_nxt;
  logic               fault_r,  fault_nxt;
  logic [STOCK_W-1:0] stock_r,  stock_nxt;
  logic [TMO_W-1:0]   timer_r,  timer_nxt;
  logic [IDX_W-1:0]   last_r,   last_nxt;
  logic               dec_s;
  logic               empty_s;
  logic [N_KIOSK-1:0] pick_s;
  logic [IDX_W-1:0]   pick_idx_s;

  iiitb_ptv_rr_pick #(
    .N_KIOSK (N_KIOSK),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req  (bus.req),
    .last (last_r),
    .pick (pick_s),
    .idx  (pick_idx_s)
  );

  assign empty_s       = (stock_r == {STOCK_W{1'b0}});
  assign bus.grant     = grant_r;
  assign bus.ack       = ack_r;
  assign bus.prn_start = start_r;
  assign bus.stock     = stock_r;
  assign bus.empty     = empty_s;
  assign bus.fault     = fault_r;

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      grant_r <= {N_KIOSK{1'b0}};
      gidx_r  <= {IDX_W{1'b0}};
      ack_r   <= {N_KIOSK{1'b0}};
      start_r <= 1'b0;
      fault_r <= 1'b0;
      stock_r <= STOCK_FULL;
      timer_r <= {TMO_W{1'b0}};
      last_r  <= LAST_INIT;
    end else begin
      state_r <= state_nxt;
      grant_r <= grant_nxt;
      gidx_r  <= gidx_nxt;
      ack_r   <= ack_nxt;
      start_r <= start_nxt;
      fault_r <= fault_nxt;
      stock_r <= stock_nxt;
      timer_r <= timer_nxt;
      last_r  <= last_nxt;
    end
  end

  // next-state, handshake outputs and stock update
  always_comb begin
    state_nxt = state_r;
    grant_nxt = grant_r;
    gidx_nxt  = gidx_r;
    ack_nxt   = {N_KIOSK{1'b0}};
    start_nxt = 1'b0;
    fault_nxt = fault_r;
    timer_nxt = timer_r;
    last_nxt  = last_r;
    dec_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if ((|pick_s) && !empty_s) begin
          grant_nxt = pick_s;
          gidx_nxt  = pick_idx_s;
          start_nxt = 1'b1;
          state_nxt = ST_START;
        end else begin
          grant_nxt = {N_KIOSK{1'b0}};
        end
      end
      ST_START: begin
        timer_nxt = {TMO_W{1'b0}};
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // a done pulse on the timeout edge still completes the ticket
        if (bus.prn_done) begin
          ack_nxt   = grant_r;
          grant_nxt = {N_KIOSK{1'b0}};
          dec_s     = 1'b1;
          last_nxt  = gidx_r;
          state_nxt = ST_IDLE;
        end else if (timer_r == TMO_LAST) begin
          grant_nxt = {N_KIOSK{1'b0}};
          fault_nxt = 1'b1;
          state_nxt = ST_FAULT;
        end else begin
          timer_nxt = timer_r + TMO_ONE;
        end
      end
      ST_FAULT: begin
        grant_nxt = {N_KIOSK{1'b0}};
        if (bus.clr_fault) begin
          fault_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          fault_nxt = 1'b1;
        end
      end
      default: begin
        grant_nxt = {N_KIOSK{1'b0}};
        fault_nxt = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase

    if (bus.refill) begin
      stock_nxt = dec_s ? (STOCK_FULL - STOCK_ONE) : STOCK_FULL;
    end else if (dec_s) begin
      stock_nxt = stock_r - STOCK_ONE;
    end else begin
      stock_nxt = stock_r;
    end
  end

endmodule

// File: tb/tb_iiitb_ptv_dispense_arb.sv
// Scoreboard bench for the dispense arbiter: expected grant/ack/fault events are
// queued with the stimulus and a forked monitor compares them as the DUT shows them.
module tb_iiitb_ptv_dispense_arb;

  localparam int NK = 4;
  localparam int SW = 8;

  localparam int EV_GRANT = 0;
  localparam int EV_ACK   = 1;
  localparam int EV_FAULT = 2;

  typedef struct {
    int         kind;
    logic [3:0] val;
    logic [7:0] stk;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run = 0;
  int   fails = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;

  iiitb_ptv_dispense_arb_if #(.N_KIOSK(NK), .STOCK_W(SW)) bus ();

  iiitb_ptv_dispense_arb #(
    .N_KIOSK       (NK),
    .STOCK_W       (SW),
    .STOCK_INIT    (3),
    .TMO_W         (5),
    .PRINT_TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [3:0] v, input logic [7:0] s);
    ev_t e;
    e.kind = kind;
    e.val  = v;
    e.stk  = s;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind, input logic [3:0] v, input logic [7:0] s);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests_run++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d value %b, expected no event", kind, v);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_value", {28'd0, v}, {28'd0, e.val});
      if (kind != EV_GRANT) begin
        check("event_stock", {24'd0, s}, {24'd0, e.stk});
      end
    end
  endtask

  task automatic monitor();
    logic fault_prev;
    fault_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.prn_start === 1'b1) take(EV_GRANT, bus.grant, bus.stock);
      if (bus.ack !== 4'b0000) take(EV_ACK, bus.ack, bus.stock);
      if (bus.fault === 1'b1 && fault_prev !== 1'b1) take(EV_FAULT, bus.grant, bus.stock);
      fault_prev = bus.fault;
    end
  endtask

  task automatic wait_start(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.prn_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests_run++;
      fails++;
      $display("FAIL prn_start_timeout: got no prn_start within 40 cycles, expected one");
    end
  endtask

  // printer model: answer delay cycles after prn_start, optionally with refill or dropping req
  task automatic serve(input int delay, input logic with_refill, input logic drop_req);
    logic ok;
    wait_start(ok);
    if (ok) begin
      if (drop_req) bus.req = 4'b0000;
      repeat (delay) @(negedge clk);
      bus.prn_done = 1'b1;
      bus.refill   = with_refill;
      @(negedge clk);
      bus.prn_done = 1'b0;
      bus.refill   = 1'b0;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic ok;
    fork
      monitor();
    join_none

    bus.req = 4'b0000; bus.prn_done = 1'b0; bus.refill = 1'b0; bus.clr_fault = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_grant", {28'd0, bus.grant}, 32'd0);
    check("reset_ack", {28'd0, bus.ack}, 32'd0);
    check("reset_stock", {24'd0, bus.stock}, 32'd3);
    check("reset_empty", {31'd0, bus.empty}, 32'd0);
    check("reset_fault", {31'd0, bus.fault}, 32'd0);

    // asynchronous reset in the middle of WAIT
    push(EV_GRANT, 4'b0001, 8'd0);
    bus.req = 4'b0001;
    wait_start(ok);
    repeat (3) @(negedge clk);
    bus.req = 4'b0000;
    #2 rst = 1'b0;
    #1;
    check("midwait_rst_grant", {28'd0, bus.grant}, 32'd0);
    check("midwait_rst_start", {31'd0, bus.prn_start}, 32'd0);
    check("midwait_rst_stock", {24'd0, bus.stock}, 32'd3);
    check("midwait_rst_fault", {31'd0, bus.fault}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // round robin between kiosks 0 and 2 until stock runs out
    push(EV_GRANT, 4'b0001, 8'd0); push(EV_ACK, 4'b0001, 8'd2);
    push(EV_GRANT, 4'b0100, 8'd0); push(EV_ACK, 4'b0100, 8'd1);
    push(EV_GRANT, 4'b0001, 8'd0); push(EV_ACK, 4'b0001, 8'd0);
    bus.req = 4'b0101;
    for (int i = 0; i < 3; i++) serve(3, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("rr_empty", {31'd0, bus.empty}, 32'd1);
    check("rr_stock", {24'd0, bus.stock}, 32'd0);
    bus.req = 4'b0000;
    bus.refill = 1'b1;
    @(negedge clk);
    bus.refill = 1'b0;
    check("refill_stock", {24'd0, bus.stock}, 32'd3);

    // stock exhaustion with all kiosks requesting, then refill serves kiosk 3
    pulse_rst();
    push(EV_GRANT, 4'b0001, 8'd0); push(EV_ACK, 4'b0001, 8'd2);
    push(EV_GRANT, 4'b0010, 8'd0); push(EV_ACK, 4'b0010, 8'd1);
    push(EV_GRANT, 4'b0100, 8'd0); push(EV_ACK, 4'b0100, 8'd0);
    bus.req = 4'b1111;
    for (int i = 0; i < 3; i++) serve(3, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("exhaust_empty", {31'd0, bus.empty}, 32'd1);
    push(EV_GRANT, 4'b1000, 8'd0); push(EV_ACK, 4'b1000, 8'd2);
    bus.refill = 1'b1;
    @(negedge clk);
    bus.refill = 1'b0;
    serve(3, 1'b0, 1'b0);
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);

    // printer timeout: fault after 16 WAIT cycles, then clear and retry
    pulse_rst();
    push(EV_GRANT, 4'b0010, 8'd0); push(EV_FAULT, 4'b0000, 8'd3);
    bus.req = 4'b0010;
    wait_start(ok);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (bus.fault === 1'b1) break;
    end
    check("timeout_cycles", n, 32'd17);
    repeat (2) @(negedge clk);
    check("fault_held", {31'd0, bus.fault}, 32'd1);
    check("fault_grant", {28'd0, bus.grant}, 32'd0);
    push(EV_GRANT, 4'b0010, 8'd0); push(EV_ACK, 4'b0010, 8'd2);
    bus.clr_fault = 1'b1;
    @(negedge clk);
    bus.clr_fault = 1'b0;
    check("fault_cleared", {31'd0, bus.fault}, 32'd0);
    serve(3, 1'b0, 1'b0);
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);

    // edge cases: done on timeout edge, refill with done, req dropped mid-WAIT
    pulse_rst();
    push(EV_GRANT, 4'b0001, 8'd0); push(EV_ACK, 4'b0001, 8'd2);
    bus.req = 4'b0001;
    serve(16, 1'b0, 1'b0);
    check("done_on_timeout_fault", {31'd0, bus.fault}, 32'd0);
    push(EV_GRANT, 4'b0001, 8'd0); push(EV_ACK, 4'b0001, 8'd2);
    serve(3, 1'b1, 1'b0);
    push(EV_GRANT, 4'b0001, 8'd0); push(EV_ACK, 4'b0001, 8'd1);
    serve(3, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // kiosks 0 and 3 both requesting
    pulse_rst();
`ifdef IIITB_PTV_PRIO_EN
    push(EV_GRANT, 4'b0001, 8'd0); push(EV_ACK, 4'b0001, 8'd2);
    push(EV_GRANT, 4'b0001, 8'd0); push(EV_ACK, 4'b0001, 8'd1);
    push(EV_GRANT, 4'b0001, 8'd0); push(EV_ACK, 4'b0001, 8'd0);
`else
    push(EV_GRANT, 4'b0001, 8'd0); push(EV_ACK, 4'b0001, 8'd2);
    push(EV_GRANT, 4'b1000, 8'd0); push(EV_ACK, 4'b1000, 8'd1);
    push(EV_GRANT, 4'b0001, 8'd0); push(EV_ACK, 4'b0001, 8'd0);
`endif
    bus.req = 4'b1001;
    for (int i = 0; i < 3; i++) serve(3, 1'b0, 1'b0);
    bus.req = 4'b0000;
    repeat (4) @(negedge clk);
    check("final_empty", {31'd0, bus.empty}, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
